// File: rtl/filt_scan_pkg.sv
// Shared definitions for the time-multiplexed debounce scheduler filt_scan.
// State encodings of the four-state glitch filter plus a small helper.
package filt_scan_pkg;

  localparam int SW = 2;

  typedef enum logic [SW-1:0] {
    Z0 = 2'd0,
    Z1 = 2'd1,
    E0 = 2'd2,
    E1 = 2'd3
  } filt_state_t;

  // Stable (non-candidate) state that corresponds to a filtered level.
  function automatic filt_state_t stable_state(input logic level);
    if (level) begin
      return E0;
    end else begin
      return Z0;
    end
  endfunction

endpackage

// File: rtl/filt_step.sv
// Single-channel combinational evaluation step of the four-state glitch filter.
// FILT_SCAN_MASK_EN adds a mask input that parks the channel in its stable state.
module filt_step
  import filt_scan_pkg::*;
#(
  parameter int CW     = 4,
  parameter int THRESH = 9
) (
  input  filt_state_t   state,
  input  logic [CW-1:0] cnt,
  input  logic          b,
  input  logic          y,
`ifdef FILT_SCAN_MASK_EN
  input  logic          mask,
`endif
  output filt_state_t   state_nxt,
  output logic [CW-1:0] cnt_nxt,
  output logic          y_nxt,
  output logic          chg
);

  localparam logic [CW-1:0] LIMIT = CW'(THRESH);
  localparam logic [CW-1:0] ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};

  // Next state/count/level; the count-exceeded test outranks input reversion.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    y_nxt     = y;
    chg       = 1'b0;
`ifdef FILT_SCAN_MASK_EN
    if (mask) begin
      state_nxt = stable_state(y);
      cnt_nxt   = ZERO;
    end else begin
`endif
    case (state)
      Z0: begin
        cnt_nxt = ZERO;
        if (b) begin
          state_nxt = Z1;
        end else begin
          state_nxt = Z0;
        end
      end
      Z1: begin
        if (cnt > LIMIT) begin
          state_nxt = E0;
          cnt_nxt   = ZERO;
          y_nxt     = 1'b1;
          chg       = (y != 1'b1);
        end else if (!b) begin
          state_nxt = Z0;
          cnt_nxt   = ZERO;
        end else begin
          cnt_nxt   = cnt + ONE;
        end
      end
      E0: begin
        cnt_nxt = ZERO;
        if (!b) begin
          state_nxt = E1;
        end else begin
          state_nxt = E0;
        end
      end
      E1: begin
        if (cnt > LIMIT) begin
          state_nxt = Z0;
          cnt_nxt   = ZERO;
          y_nxt     = 1'b0;
          chg       = (y != 1'b0);
        end else if (b) begin
          state_nxt = E0;
          cnt_nxt   = ZERO;
        end else begin
          cnt_nxt   = cnt + ONE;
        end
      end
      default: begin
        state_nxt = Z0;
        cnt_nxt   = ZERO;
      end
    endcase
`ifdef FILT_SCAN_MASK_EN
    end
`endif
  end

endmodule

// File: rtl/filt_scan.sv
// Round-robin debounce scheduler: one shared filt_step services one channel per enabled clock.
// Optional FILT_SCAN_MASK_EN adds a per-channel mask input.
module filt_scan
  import filt_scan_pkg::*;
#(
  parameter int N      = 4,
  parameter int CW     = 4,
  parameter int THRESH = 9
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [N-1:0]                         i,
`ifdef FILT_SCAN_MASK_EN
  input  logic [N-1:0]                         mask,
`endif
  output logic [N-1:0]                         y,
  output logic                                 chg,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] chg_idx,
  output logic                                 sweep
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] ptr;
  filt_state_t   st  [N];
  logic [CW-1:0] cnt [N];

  filt_state_t   st_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          y_nxt;
  logic          step_chg;

  filt_step #(
    .CW     (CW),
    .THRESH (THRESH)
  ) u_step (
    .state     (st[ptr]),
    .cnt       (cnt[ptr]),
    .b         (i[ptr]),
    .y         (y[ptr]),
`ifdef FILT_SCAN_MASK_EN
    .mask      (mask[ptr]),
`endif
    .state_nxt (st_nxt),
    .cnt_nxt   (cnt_nxt),
    .y_nxt     (y_nxt),
    .chg       (step_chg)
  );

  // Pointer, serviced-channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= PTR_ZERO;
      y       <= {N{1'b0}};
      chg     <= 1'b0;
      chg_idx <= PTR_ZERO;
      sweep   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        st[k]  <= Z0;
        cnt[k] <= {CW{1'b0}};
      end
    end else if (en) begin
      st[ptr]  <= st_nxt;
      cnt[ptr] <= cnt_nxt;
      y[ptr]   <= y_nxt;
      chg      <= step_chg;
      if (step_chg) begin
        chg_idx <= ptr;
      end else begin
        chg_idx <= chg_idx;
      end
      sweep <= (ptr == PTR_LAST);
      // Explicit wrap keeps non-power-of-two N in range.
      if (ptr == PTR_LAST) begin
        ptr <= PTR_ZERO;
      end else begin
        ptr <= ptr + PTR_ONE;
      end
    end else begin
      chg   <= 1'b0;
      sweep <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filt_scan.sv
// Self-checking bench for filt_scan: directed scenarios plus randomized stimulus
// against a run-length reference model of the debounce behaviour.
module tb_filt_scan;

  localparam int N  = 4;
  localparam int TH = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] i;
  logic [N-1:0] y;
  logic         chg;
  logic [1:0]   chg_idx;
  logic         sweep;
`ifdef FILT_SCAN_MASK_EN
  logic [N-1:0] mask = 4'b0000;
`endif

  filt_scan #(.N(N), .CW(4), .THRESH(TH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i       (i),
`ifdef FILT_SCAN_MASK_EN
    .mask    (mask),
`endif
    .y       (y),
    .chg     (chg),
    .chg_idx (chg_idx),
    .sweep   (sweep)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per channel, the number of consecutive services that saw
  // the input disagree with the filtered level. Once that run has reached
  // TH+2, the next service accepts the new level whatever the input is.
  int           m_ptr;
  int           m_run [N];
  logic [N-1:0] m_y;
  logic         m_chg;
  logic [1:0]   m_idx;
  logic         m_sweep;
  int           cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic masked;
    if (rst) begin
      m_ptr = 0;
      for (int k = 0; k < N; k++) m_run[k] = 0;
      m_y = '0; m_chg = 1'b0; m_idx = 2'd0; m_sweep = 1'b0;
    end else if (en) begin
      masked = 1'b0;
`ifdef FILT_SCAN_MASK_EN
      masked = mask[m_ptr];
`endif
      m_chg = 1'b0;
      if (masked) begin
        m_run[m_ptr] = 0;
      end else if (m_run[m_ptr] >= TH + 2) begin
        m_y[m_ptr] = ~m_y[m_ptr];
        m_run[m_ptr] = 0;
        m_chg = 1'b1;
        m_idx = 2'(m_ptr);
      end else if (i[m_ptr] != m_y[m_ptr]) begin
        m_run[m_ptr]++;
      end else begin
        m_run[m_ptr] = 0;
      end
      m_sweep = (m_ptr == N - 1);
      m_ptr = (m_ptr + 1) % N;
    end else begin
      m_chg = 1'b0;
      m_sweep = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    if (rst) cyc = 0; else cyc++;
    #1;
    check("y", 32'(y), 32'(m_y));
    check("chg", 32'(chg), 32'(m_chg));
    check("chg_idx", 32'(chg_idx), 32'(m_idx));
    check("sweep", 32'(sweep), 32'(m_sweep));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; i = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  int found, sweeps, chgs;

  initial begin
    cyc = 0;
    m_ptr = 0; m_y = '0; m_chg = 1'b0; m_idx = 2'd0; m_sweep = 1'b0;
    for (int k = 0; k < N; k++) m_run[k] = 0;

    // Reset state and idle scanning
    do_reset();
    check("rst_y", 32'(y), 32'd0);
    en = 1'b1; sweeps = 0; chgs = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (sweep) sweeps++;
      if (chg) chgs++;
    end
    check("idle_sweeps", 32'(sweeps), 32'd10);
    check("idle_chgs", 32'(chgs), 32'd0);

    // Channel 0 accepted on its 12th service (cycle 44)
    do_reset();
    en = 1'b1; i = 4'b0001; found = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (chg && found < 0) found = c;
    end
    check("acc0_cycle", 32'(found), 32'd44);
    check("acc0_y", 32'(y), 32'd1);

    // Short glitch on channel 2 (5 services) is rejected
    do_reset();
    en = 1'b1; chgs = 0;
    for (int c = 0; c < 60; c++) begin
      i = (c < 19) ? 4'b0100 : 4'b0000;
      tick();
      if (chg) chgs++;
    end
    check("glitch_y", 32'(y), 32'd0);
    check("glitch_chgs", 32'(chgs), 32'd0);

    // en low for 20 cycles delays channel-1 acceptance by 20 cycles (45 -> 65)
    do_reset();
    i = 4'b0010; found = -1;
    for (int c = 0; c < 200; c++) begin
      en = !(c >= 20 && c < 40);
      tick();
      if (chg && found < 0) found = c;
    end
    en = 1'b1;
    check("pause_cycle", 32'(found), 32'd65);

    // Reset while channel 3 sits in E1 with cnt=5
    do_reset();
    en = 1'b1; i = 4'b1000; found = -1;
    for (int c = 0; c < 100 && found < 0; c++) begin
      tick();
      if (y[3]) found = c;
    end
    check("ch3_accept", 32'(found), 32'd47);
    i = 4'b0000;
    repeat (24) tick();
    rst = 1'b1;
    tick();
    check("midrst_y", 32'(y), 32'd0);
    check("midrst_chg", 32'(chg), 32'd0);
    rst = 1'b0; i = 4'b1000; found = -1; sweeps = -1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (sweep && sweeps < 0) sweeps = c;
      if (chg && found < 0) found = c;
    end
    check("midrst_ptr0", 32'(sweeps), 32'd3);
    check("midrst_acc", 32'(found), 32'd47);

`ifdef FILT_SCAN_MASK_EN
    // Masked channel 0 ignores stable toggling
    do_reset();
    en = 1'b1; mask = 4'b0001; chgs = 0;
    for (int c = 0; c < 400; c++) begin
      i = ((c / 100) % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (chg && chg_idx == 2'd0) chgs++;
    end
    check("mask_y0", 32'(y[0]), 32'd0);
    check("mask_chgs", 32'(chgs), 32'd0);
`endif

    // Randomized traffic with sparse input flips, en gaps and occasional reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(63, 0) == 0) i[k] = ~i[k];
      en  = ($urandom_range(9, 0) != 0);
      rst = ($urandom_range(499, 0) == 0);
`ifdef FILT_SCAN_MASK_EN
      if ($urandom_range(199, 0) == 0) mask = 4'($urandom);
`endif
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
